// File: rtl/fde_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control unit: sequences the datapath
// enables, handles NOP/HALT opcodes, ALU stalls, fetch timeout and a retired count.
module fde_sequencer #(
    parameter logic [3:0] OP_NOP      = 4'h0,
    parameter logic [3:0] OP_HALT     = 4'hF,
    parameter int         MEM_TIMEOUT = 8,
    parameter int         COUNT_W     = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_mem_ready,
    input  logic [3:0]         i_opcode,
    input  logic               i_stall,
    output logic               o_mem_req,
    output logic               o_ir_load,
    output logic               o_rf_read_en,
    output logic               o_alu_en,
    output logic               o_write_en,
    output logic               o_pc_en,
    output logic               o_busy,
    output logic               o_halted,
    output logic               o_error,
    output logic [2:0]         o_state,
    output logic [COUNT_W-1:0] o_instr_count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5,
        ERROR     = 3'd6
    } state_t;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               retire;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    // Ready on the last permitted fetch cycle still wins over the timeout.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) state_d = FETCH;
            end
            FETCH: begin
                if (i_mem_ready) begin
                    state_d = DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DECODE: begin
                if (i_opcode == OP_HALT) begin
                    state_d = HALT;
                    retire  = 1'b1;
                end else if (i_opcode == OP_NOP) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                if (!i_stall) state_d = WRITEBACK;
            end
            WRITEBACK: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            HALT: begin
                if (i_start) state_d = FETCH;
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        count_d = (retire && (count_q != '1)) ? count_q + 1'b1 : count_q;
    end

    // Resuming from HALT advances the PC past the halt instruction itself.
    always_comb begin
        o_mem_req    = 1'b0;
        o_ir_load    = 1'b0;
        o_rf_read_en = 1'b0;
        o_alu_en     = 1'b0;
        o_write_en   = 1'b0;
        o_pc_en      = 1'b0;
        o_busy       = 1'b0;
        o_halted     = 1'b0;
        o_error      = 1'b0;
        case (state_q)
            FETCH: begin
                o_mem_req = 1'b1;
                o_ir_load = i_mem_ready;
                o_busy    = 1'b1;
            end
            DECODE: begin
                o_rf_read_en = 1'b1;
                o_pc_en      = (i_opcode == OP_NOP) && (i_opcode != OP_HALT);
                o_busy       = 1'b1;
            end
            EXECUTE: begin
                o_alu_en = 1'b1;
                o_busy   = 1'b1;
            end
            WRITEBACK: begin
                o_write_en = 1'b1;
                o_pc_en    = 1'b1;
                o_busy     = 1'b1;
            end
            HALT: begin
                o_halted = 1'b1;
                o_pc_en  = i_start;
            end
            ERROR: begin
                o_error = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_state       = state_q;
    assign o_instr_count = count_q;

endmodule

// File: tb/tb_fde_sequencer.sv
// Scoreboarded bench for fde_sequencer: a per-cycle reference model queues expected
// outputs while a negedge monitor pops and compares them against the DUT.
module tb_fde_sequencer;

    localparam int CW   = 4;
    localparam int TMO  = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_start;
    logic          i_mem_ready;
    logic [3:0]    i_opcode;
    logic          i_stall;
    logic          o_mem_req, o_ir_load, o_rf_read_en, o_alu_en, o_write_en, o_pc_en;
    logic          o_busy, o_halted, o_error;
    logic [2:0]    o_state;
    logic [CW-1:0] o_instr_count;

    always #5 clk = ~clk;

    fde_sequencer #(
        .OP_NOP(4'h0),
        .OP_HALT(4'hF),
        .MEM_TIMEOUT(TMO),
        .COUNT_W(CW)
    ) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .i_start(i_start),
        .i_mem_ready(i_mem_ready),
        .i_opcode(i_opcode),
        .i_stall(i_stall),
        .o_mem_req(o_mem_req),
        .o_ir_load(o_ir_load),
        .o_rf_read_en(o_rf_read_en),
        .o_alu_en(o_alu_en),
        .o_write_en(o_write_en),
        .o_pc_en(o_pc_en),
        .o_busy(o_busy),
        .o_halted(o_halted),
        .o_error(o_error),
        .o_state(o_state),
        .o_instr_count(o_instr_count)
    );

    logic [15:0] actual;
    assign actual = {o_mem_req, o_ir_load, o_rf_read_en, o_alu_en, o_write_en, o_pc_en,
                     o_busy, o_halted, o_error, o_state, o_instr_count};

    logic [15:0] expQ[$];
    int nVec = 0;
    int nMis = 0;

    // Reference model: phase numbers follow the published state encoding.
    int mState = 0;
    int mWait  = 0;
    int mCount = 0;

    task automatic applyStimulus(input logic start, input logic ready,
                                 input logic [3:0] op, input logic stall);
        logic [8:0] s;
        int nxt;
        int nW;
        logic ret;
        i_start     = start;
        i_mem_ready = ready;
        i_opcode    = op;
        i_stall     = stall;
        s   = '0;
        nxt = mState;
        nW  = 0;
        ret = 1'b0;
        case (mState)
            0: if (start) nxt = 1;
            1: begin
                s[8] = 1'b1; s[2] = 1'b1;
                if (ready) begin
                    s[7] = 1'b1; nxt = 2;
                end else begin
                    nW = mWait + 1;
                    if (nW >= TMO) nxt = 6;
                end
            end
            2: begin
                s[6] = 1'b1; s[2] = 1'b1;
                if (op == 4'hF) begin
                    nxt = 5; ret = 1'b1;
                end else if (op == 4'h0) begin
                    s[3] = 1'b1; nxt = 1; ret = 1'b1;
                end else begin
                    nxt = 3;
                end
            end
            3: begin
                s[5] = 1'b1; s[2] = 1'b1;
                if (!stall) nxt = 4;
            end
            4: begin
                s[4] = 1'b1; s[3] = 1'b1; s[2] = 1'b1;
                ret = 1'b1; nxt = 1;
            end
            5: begin
                s[1] = 1'b1;
                if (start) begin
                    s[3] = 1'b1; nxt = 1;
                end
            end
            default: s[0] = 1'b1;
        endcase
        expQ.push_back({s, 3'(mState), CW'(mCount)});
        @(posedge clk);
        mState = nxt;
        mWait  = nW;
        if (ret) mCount = (mCount + 1 > MAXC) ? MAXC : mCount + 1;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] want);
        nVec++;
        if (actual !== want) begin
            nMis++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, want, $time);
        end
    endtask

    // Reset lands between clock edges; outputs must clear before the next edge.
    task automatic applyReset();
        #2 i_reset = 1'b1;
        #1 checkOutput("async reset outputs", 16'h0000);
        mState = 0;
        mWait  = 0;
        mCount = 0;
        @(posedge clk);
        #1 i_reset = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        if (!i_reset && expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("cycle outputs", e);
            nVec++;
            if ($countones({o_ir_load, o_rf_read_en, o_alu_en, o_write_en}) > 1) begin
                nMis++;
                $display("[TB] FAIL strobe overlap: got %b want at most one set",
                         {o_ir_load, o_rf_read_en, o_alu_en, o_write_en});
            end
        end
    end

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_mem_ready = 1'b0; i_opcode = 4'h0; i_stall = 1'b0;
        @(posedge clk);
        #1 checkOutput("power-on reset", 16'h0000);
        i_reset = 1'b0;

        // ALU instruction loop with ready always high
        applyStimulus(1, 1, 4'h3, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 4'h3, 0);

        // NOP, ADD, HALT then resume
        applyReset();
        applyStimulus(1, 1, 4'h0, 0);
        applyStimulus(0, 1, 4'h0, 0);
        applyStimulus(0, 1, 4'h0, 0);
        applyStimulus(0, 1, 4'h2, 0);
        applyStimulus(0, 1, 4'h2, 0);
        applyStimulus(0, 1, 4'h2, 0);
        applyStimulus(0, 1, 4'h2, 0);
        applyStimulus(0, 1, 4'hF, 0);
        applyStimulus(0, 1, 4'hF, 0);
        applyStimulus(0, 1, 4'hF, 0);
        applyStimulus(0, 1, 4'hF, 0);
        applyStimulus(1, 1, 4'h3, 0);
        applyStimulus(0, 1, 4'h3, 0);

        // Fetch wait then timeout into sticky error
        applyReset();
        applyStimulus(1, 0, 4'h0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4'h0, 0);
        applyStimulus(0, 1, 4'h0, 0);
        applyStimulus(0, 0, 4'h0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 4'h0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 4'h0, 0);

        // Ready arriving on the last permitted wait cycle
        applyReset();
        applyStimulus(1, 0, 4'h0, 0);
        for (int i = 0; i < TMO - 1; i++) applyStimulus(0, 0, 4'h0, 0);
        applyStimulus(0, 1, 4'h0, 0);
        applyStimulus(0, 1, 4'h0, 0);

        // Five-cycle ALU stall
        applyReset();
        applyStimulus(1, 1, 4'h5, 0);
        applyStimulus(0, 1, 4'h5, 0);
        applyStimulus(0, 1, 4'h5, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 4'h5, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 4'h5, 0);

        // Asynchronous reset in the middle of EXECUTE, then idle
        applyReset();
        applyStimulus(1, 1, 4'h7, 0);
        applyStimulus(0, 1, 4'h7, 0);
        applyStimulus(0, 1, 4'h7, 0);
        applyStimulus(0, 1, 4'h7, 1);
        applyStimulus(0, 1, 4'h7, 1);
        applyReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 4'h7, 0);

        // Counter saturation with a stream of NOPs
        applyReset();
        applyStimulus(1, 1, 4'h0, 0);
        for (int i = 0; i < 38; i++) applyStimulus(0, 1, 4'h0, 0);

        // Randomized traffic, re-reset per chunk to escape the sticky error
        for (int c = 0; c < 6; c++) begin
            applyReset();
            for (int i = 0; i < 80; i++) begin
                logic [3:0] op;
                case ($urandom_range(3))
                    0: op = 4'h0;
                    1: op = 4'hF;
                    default: op = 4'($urandom_range(15));
                endcase
                applyStimulus(($urandom_range(7) == 0), ($urandom_range(3) != 0), op,
                              ($urandom_range(2) == 0));
            end
        end

        @(negedge clk);
        #1;
        nVec++;
        if (expQ.size() != 0) begin
            nMis++;
            $display("[TB] FAIL scoreboard drain: got %0d pending want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
